fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/program_counter.sv | 35 +++
 rtl/fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package fetch_pkg;

    localparam int FETCH_ADDR_W      = 8;
    localparam int FETCH_DATA_W      = 8;
    localparam int FETCH_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_AR  = 2'd1,
        WAIT_MEM = 2'd2,
        VALID    = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register: a parallel load takes priority over the +1 step.
module program_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (inc) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch: issue address, wait on memory, hold the word until
// the decoder accepts it. A jump redirects the PC and abandons any fetch in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = FETCH_ADDR_W,
    parameter int DATA_W      = FETCH_DATA_W,
    parameter int WAIT_CYCLES = FETCH_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ar_load,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    fetch_state_e      state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              pc_load;
    logic              pc_inc;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;

        // Once an address is issued, the fetch completes regardless of run.
        case (state_q)
            IDLE: begin
                if (run) state_d = LOAD_AR;
            end
            LOAD_AR: begin
                if (WAIT_CYCLES > 0) begin
                    state_d    = WAIT_MEM;
                    wait_cnt_d = WAIT_LD;
                end else begin
                    state_d = VALID;
                end
            end
            WAIT_MEM: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) state_d = VALID;
            end
            VALID: begin
                if (instr_ready) state_d = run ? LOAD_AR : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (jump_valid) begin
            state_d = run ? LOAD_AR : IDLE;
            pc_load = 1'b1;
        end

        pc_inc = (state_d == VALID) && (state_q != VALID);
        if (pc_inc) instr_d = mem_data;

        // The jump target becomes the PC on this same edge, so issue it directly.
        if (state_d == LOAD_AR) mem_addr_d = jump_valid ? jump_addr : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_addr_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
        end
    end

    program_counter #(
        .W (ADDR_W)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load       (pc_load),
        .load_value (jump_addr),
        .inc        (pc_inc),
        .value      (pc)
    );

    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign ar_load     = (state_q == LOAD_AR);
    assign instr_valid = (state_q == VALID);

endmodule
